// File: rtl/gram_ddrphy_pkg.sv
// Shared types and defaults for the ECP5 DDR PHY clocking sequencer.
package gram_ddrphy_pkg;

  localparam int DDRPHY_WAIT_CYCLES = 8;
  localparam int DDRPHY_LOCK_FILTER = 16;

  typedef enum logic [2:0] {
    LOCK_WAIT,
    RELEASE_RST,
    UNSTOP,
    UNPAUSE,
    READY,
    UPD_PAUSE,
    UPD_PULSE,
    UPD_RELEASE
  } ddrphy_state_t;

endpackage

// File: rtl/init_dwell_counter.sv
// Clear/enable up-counter that saturates at a programmable terminal value;
// shared by the lock filter and the per-phase dwell timer.
module init_dwell_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] last,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  assign tc = (count == last);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ddrphy_init_sequencer.sv
// Power-up and DLL-update sequencer for the ECP5 DDR clock tree: orders
// CLKDIV reset, ECLKSYNC stop, DQS/DLL pause and uddcntln after lock.
module ddrphy_init_sequencer
  import gram_ddrphy_pkg::*;
#(
  parameter int WAIT_CYCLES = DDRPHY_WAIT_CYCLES,
  parameter int LOCK_FILTER = DDRPHY_LOCK_FILTER
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_lock,
  input  logic dll_lock,
  input  logic update_req,
  output logic ddr_rst,
  output logic stop,
  output logic pause,
  output logic uddcntln,
  output logic ready,
  output logic update_ack
);

  localparam int MAX_COUNT = (WAIT_CYCLES > LOCK_FILTER) ? WAIT_CYCLES : LOCK_FILTER;
  localparam int CW        = $clog2(MAX_COUNT + 1);
  localparam logic [CW-1:0] WAIT_LAST   = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] FILTER_LAST = CW'(LOCK_FILTER - 1);

  ddrphy_state_t state_q, state_d;
  logic          locked;
  logic          cnt_tc;
  logic          cnt_clr;
  logic [CW-1:0] cnt_last;
  logic          ddr_rst_d, stop_d, pause_d, uddcntln_d, ready_d, update_ack_d;

  assign locked = pll_lock & dll_lock;

  // The terminal value is one less than the dwell because the transition
  // itself is taken on the edge that would complete the last cycle.
  assign cnt_last = (state_q == LOCK_WAIT) ? FILTER_LAST : WAIT_LAST;
  assign cnt_clr  = (state_d != state_q) || !locked || (state_q == READY);

  init_dwell_counter #(
    .WIDTH(CW)
  ) u_dwell (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (1'b1),
    .last(cnt_last),
    .tc  (cnt_tc)
  );

  // NOTE: every always_comb output gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    if (!locked) begin
      state_d = LOCK_WAIT;
    end else begin
      unique case (state_q)
        LOCK_WAIT:   if (cnt_tc)     state_d = RELEASE_RST;
        RELEASE_RST: if (cnt_tc)     state_d = UNSTOP;
        UNSTOP:      if (cnt_tc)     state_d = UNPAUSE;
        UNPAUSE:     if (cnt_tc)     state_d = READY;
        READY:       if (update_req) state_d = UPD_PAUSE;
        UPD_PAUSE:   if (cnt_tc)     state_d = UPD_PULSE;
        UPD_PULSE:   if (cnt_tc)     state_d = UPD_RELEASE;
        UPD_RELEASE: if (cnt_tc)     state_d = READY;
        default:                     state_d = LOCK_WAIT;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register on the same
  // edge as the state change.
  always_comb begin
    ddr_rst_d    = 1'b1;
    stop_d       = 1'b1;
    pause_d      = 1'b1;
    uddcntln_d   = 1'b1;
    ready_d      = 1'b0;
    update_ack_d = (state_q == UPD_RELEASE) && (state_d == READY);
    unique case (state_d)
      LOCK_WAIT: ;
      RELEASE_RST: ddr_rst_d = 1'b0;
      UNSTOP: begin
        ddr_rst_d = 1'b0;
        stop_d    = 1'b0;
      end
      UNPAUSE: begin
        ddr_rst_d = 1'b0;
        stop_d    = 1'b0;
        pause_d   = 1'b0;
      end
      READY: begin
        ddr_rst_d = 1'b0;
        stop_d    = 1'b0;
        pause_d   = 1'b0;
        ready_d   = 1'b1;
      end
      UPD_PAUSE, UPD_RELEASE: begin
        ddr_rst_d = 1'b0;
        stop_d    = 1'b0;
      end
      UPD_PULSE: begin
        ddr_rst_d  = 1'b0;
        stop_d     = 1'b0;
        uddcntln_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOCK_WAIT;
      ddr_rst    <= 1'b1;
      stop       <= 1'b1;
      pause      <= 1'b1;
      uddcntln   <= 1'b1;
      ready      <= 1'b0;
      update_ack <= 1'b0;
    end else begin
      state_q    <= state_d;
      ddr_rst    <= ddr_rst_d;
      stop       <= stop_d;
      pause      <= pause_d;
      uddcntln   <= uddcntln_d;
      ready      <= ready_d;
      update_ack <= update_ack_d;
    end
  end

endmodule

// File: tb/tb_ddrphy_init_sequencer.sv
// Directed bench for ddrphy_init_sequencer: table-driven power-up vectors
// plus hand-written update, lock-loss, glitch and async-reset sequences.
module tb_ddrphy_init_sequencer;

  logic clk = 1'b0;
  logic rst, pll_lock, dll_lock, update_req;
  logic ddr_rst, stop, pause, uddcntln, ready, update_ack;

  int tests = 0;
  int fails = 0;
  int cur_edge;

  // Expected output vector order: {ddr_rst, stop, pause, uddcntln, ready, update_ack}
  localparam logic [5:0] RST_VAL = 6'b111100;

  typedef struct {
    int         edge_no;
    logic       pll;
    logic       dll;
    logic       req;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[9];

  always #5 clk = ~clk;

  ddrphy_init_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .pll_lock  (pll_lock),
    .dll_lock  (dll_lock),
    .update_req(update_req),
    .ddr_rst   (ddr_rst),
    .stop      (stop),
    .pause     (pause),
    .uddcntln  (uddcntln),
    .ready     (ready),
    .update_ack(update_ack)
  );

  function automatic logic [5:0] outs();
    return {ddr_rst, stop, pause, uddcntln, ready, update_ack};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, cur_edge);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cur_edge++;
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    pll_lock   = 1'b1;
    dll_lock   = 1'b1;
    update_req = 1'b0;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    cur_edge = 0;
  endtask

  initial begin
    int ack_seen;

    // Power-up with both locks high; update_req held high must be ignored.
    tbl[0] = '{0,  1'b1, 1'b1, 1'b1, 6'b111100};
    tbl[1] = '{15, 1'b1, 1'b1, 1'b1, 6'b111100};
    tbl[2] = '{16, 1'b1, 1'b1, 1'b1, 6'b011100};
    tbl[3] = '{23, 1'b1, 1'b1, 1'b1, 6'b011100};
    tbl[4] = '{24, 1'b1, 1'b1, 1'b1, 6'b001100};
    tbl[5] = '{31, 1'b1, 1'b1, 1'b1, 6'b001100};
    tbl[6] = '{32, 1'b1, 1'b1, 1'b1, 6'b000100};
    tbl[7] = '{39, 1'b1, 1'b1, 1'b1, 6'b000100};
    tbl[8] = '{40, 1'b1, 1'b1, 1'b1, 6'b000110};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      pll_lock   = tbl[i].pll;
      dll_lock   = tbl[i].dll;
      update_req = tbl[i].req;
      while (cur_edge < tbl[i].edge_no) tick(1);
      check($sformatf("powerup_e%0d", tbl[i].edge_no), outs(), tbl[i].exp);
    end

    // Request not latched from before READY: dropping it now keeps READY.
    update_req = 1'b0;
    tick(1);
    check("req_not_latched", outs(), 6'b000110);

    // Single update pulse at edge k.
    update_req = 1'b1;
    tick(1);
    update_req = 1'b0;
    check("upd_k", outs(), 6'b001100);
    tick(7);
    check("upd_k+7", outs(), 6'b001100);
    tick(1);
    check("upd_k+8", outs(), 6'b001000);
    tick(7);
    check("upd_k+15", outs(), 6'b001000);
    tick(1);
    check("upd_k+16", outs(), 6'b001100);
    tick(7);
    check("upd_k+23", outs(), 6'b001100);
    tick(1);
    check("upd_k+24_ack", outs(), 6'b000111);
    tick(1);
    check("upd_k+25", outs(), 6'b000110);

    // Held request: back-to-back updates, acks 25 edges apart.
    update_req = 1'b1;
    tick(25);
    check("b2b_ack1", outs(), 6'b000111);
    tick(1);
    check("b2b_restart", outs(), 6'b001100);
    tick(23);
    check("b2b_before_ack2", outs(), 6'b001100);
    tick(1);
    update_req = 1'b0;
    check("b2b_ack2", outs(), 6'b000111);
    tick(1);
    check("b2b_idle", outs(), 6'b000110);

    // dll_lock lost during UPD_PULSE: no ack, outputs back to reset values.
    update_req = 1'b1;
    tick(1);
    update_req = 1'b0;
    tick(10);
    check("abort_in_pulse", outs(), 6'b001000);
    dll_lock = 1'b0;
    tick(1);
    check("abort_reset_vals", outs(), RST_VAL);
    tick(5);
    check("abort_hold", outs(), RST_VAL);
    dll_lock = 1'b1;
    ack_seen = 0;
    for (int i = 0; i < 39; i++) begin
      tick(1);
      if (update_ack) ack_seen++;
    end
    check("abort_no_ack", 6'(ack_seen), 6'd0);
    check("abort_reseq_e39", outs(), 6'b000100);
    tick(1);
    check("abort_reseq_e40", outs(), 6'b000110);

    // pll_lock glitch sampled at edge 10 restarts the filter.
    do_reset();
    tick(9);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    check("glitch_e10", outs(), RST_VAL);
    tick(15);
    check("glitch_e25", outs(), RST_VAL);
    tick(1);
    check("glitch_e26", outs(), 6'b011100);
    tick(23);
    check("glitch_e49", outs(), 6'b000100);
    tick(1);
    check("glitch_e50", outs(), 6'b000110);

    // Asynchronous reset in the middle of UNSTOP.
    do_reset();
    tick(28);
    check("unstop_e28", outs(), 6'b001100);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", outs(), RST_VAL);
    #20;
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
